// File: rtl/sign_extend_pkg.sv
// sign_extend_pkg: Extop encodings and widths shared by decoder and extension unit
package sign_extend_pkg;
   localparam int IMM_W = 24;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {
      EXT_ZERO24 = 2'b00,
      EXT_SIGN24 = 2'b01,
      EXT_BRANCH = 2'b10,
      EXT_SIGN12 = 2'b11
   } extop_e;
endpackage

// File: rtl/sign_extend_core.sv
// sign_extend_core: combinational immediate extension mode mux
module sign_extend_core
   import sign_extend_pkg::*;
(
   input  logic [IMM_W-1:0] imm,
   input  logic [1:0]       Extop,
   output logic [XLEN-1:0]  ext
);
   always_comb begin
      ext = (Extop == EXT_ZERO24) ? {8'h00, imm} :
            (Extop == EXT_SIGN24) ? {{8{imm[23]}}, imm} :
            (Extop == EXT_BRANCH) ? {{6{imm[23]}}, imm, 2'b00} :
                                    {{20{imm[11]}}, imm[11:0]};
   end
endmodule

// File: rtl/sign_extend.sv
// sign_extend: registered 24-to-32-bit immediate extension for the decode path
module sign_extend
   import sign_extend_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IMM_W-1:0] imm,
   input  logic [1:0]       Extop,
   input  logic             in_valid,
   output logic [XLEN-1:0]  imm32,
   output logic             out_valid
);
   logic [XLEN-1:0] ext;
   sign_extend_core u_core (
      .imm   (imm),
      .Extop (Extop),
      .ext   (ext)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm32     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) imm32 <= ext;
      end
   end
endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: scoreboard-based self-checking bench for sign_extend
module tb_sign_extend;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] imm = '0;
   logic [1:0]  Extop = '0;
   logic        in_valid = 1'b0;
   logic [31:0] imm32;
   logic        out_valid;
   logic [31:0] sb[$];
   int          n_checks = 0;
   int          n_fail = 0;

   sign_extend dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imm       (imm),
      .Extop     (Extop),
      .in_valid  (in_valid),
      .imm32     (imm32),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Reference built from signed arithmetic rather than bit concatenation
   function automatic logic [31:0] model(input logic [23:0] i, input logic [1:0] op);
      logic signed [31:0] s24;
      logic signed [31:0] s12;
      s24 = 32'(signed'(i));
      s12 = 32'(signed'(i[11:0]));
      case (op)
         2'b00: return 32'(i);
         2'b01: return s24;
         2'b10: return s24 * 4;
         default: return s12;
      endcase
   endfunction

   task automatic drive(input logic [23:0] i, input logic [1:0] op, input logic v, input logic [31:0] exp);
      @(negedge clk);
      imm = i;
      Extop = op;
      in_valid = v;
      if (v) sb.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic check_pop(input string name);
      logic [31:0] exp;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, imm32=%h out_valid=%b", name, imm32, out_valid);
      end else begin
         exp = sb.pop_front();
         if (imm32 !== exp || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: imm32=%h out_valid=%b, required %h/1", name, imm32, out_valid, exp);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (imm32 !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: imm32=%h out_valid=%b, required 0/0", imm32, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_pattern(input logic [23:0] i, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input string name);
      logic [31:0] exp[4];
      exp = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         drive(i, 2'(k), 1'b1, exp[k]);
         check_pop($sformatf("%s_op%0d", name, k));
      end
   endtask

   task automatic test_boundaries();
      drive(24'h800000, 2'b01, 1'b1, 32'hFF800000); check_pop("bnd_800000_sign24");
      drive(24'h800000, 2'b10, 1'b1, 32'hFE000000); check_pop("bnd_800000_branch");
      drive(24'h7FF800, 2'b11, 1'b1, 32'hFFFFF800); check_pop("bnd_7ff800_sign12");
      drive(24'h7FF800, 2'b01, 1'b1, 32'h007FF800); check_pop("bnd_7ff800_sign24");
   endtask

   task automatic test_hold();
      drive(24'hFFFFFF, 2'b01, 1'b1, 32'hFFFFFFFF);
      check_pop("hold_load");
      for (int k = 0; k < 2; k++) begin
         drive(24'h000001, 2'(k), 1'b0, 32'h0);
         n_checks++;
         if (imm32 !== 32'hFFFFFFFF || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: imm32=%h out_valid=%b, required ffffffff/0", k, imm32, out_valid);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(24'h123456, 2'b01, 1'b1, 32'h00123456);
      check_pop("areset_pre");
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (imm32 !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: imm32=%h out_valid=%b, required 0/0", imm32, out_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (imm32 !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held: imm32=%h out_valid=%b, required 0/0", imm32, out_valid);
      end
      sb.delete();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_recovery();
      drive(24'h000010, 2'b10, 1'b1, 32'h00000040);
      check_pop("recovery");
   endtask

   task automatic test_back_to_back();
      logic [23:0] i;
      logic [1:0]  op;
      for (int k = 0; k < 24; k++) begin
         i = 24'($urandom);
         op = 2'($urandom_range(0, 3));
         drive(i, op, 1'b1, model(i, op));
         check_pop($sformatf("b2b_%0d_op%0d_%h", k, op, i));
      end
      drive(24'h0, 2'b00, 1'b0, 32'h0);
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: out_valid=%b pending=%0d, required 0/0", out_valid, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_pattern(24'h123456, 32'h00123456, 32'h00123456, 32'h0048D158, 32'h00000456, "pat_123456");
      test_pattern(24'hFFFFFF, 32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFF, "pat_ffffff");
      test_boundaries();
      test_hold();
      test_async_reset();
      test_recovery();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sign_extend.md
# sign_extend

Immediate-extension unit for the CPU decode path. It takes the 24-bit immediate field from the instruction and produces a 32-bit operand. The extension mode is selected by the decoder's `Extop` control. The result is registered once before it reaches the execute stage's operand muxes.

## Interface
- No parameters. Widths are fixed: 24-bit immediate in, 32-bit result out.
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `imm` — input, 24 — raw immediate field, `imm[23:0]`.
- `Extop` — input, 2 — extension mode select.
- `in_valid` — input, 1 — `imm`/`Extop` are valid this cycle.
- `imm32` — output, 32 — registered extended immediate.
- `out_valid` — output, 1 — `imm32` holds a result captured from a valid input.

## Operation
- `Extop` = 00, ZERO24: `imm32 = {8'h00, imm[23:0]}`.
- `Extop` = 01, SIGN24: `imm32 = {{8{imm[23]}}, imm[23:0]}`.
- `Extop` = 10, BRANCH (word offset): `imm32 = {{6{imm[23]}}, imm[23:0], 2'b00}`. This is sign-extend then shift left by 2; bits [1:0] are always 0.
- `Extop` = 11, SIGN12: `imm32 = {{20{imm[11]}}, imm[11:0]}`. `imm[23:12]` is ignored.
- No encoding is illegal. All four modes are fully defined.
- Pure function of (`imm`, `Extop`). There is no internal state other than the output register.

## Timing
- Reset (`rst_n` low, asynchronous): `imm32` = 32'h0000_0000 and `out_valid` = 0 immediately, independent of `clk`.
- Reset release: the first capture happens on the first rising edge where `rst_n` is high.
- Latency is 1 cycle. When `in_valid` = 1 at edge N, the result of that cycle's `imm`/`Extop` appears on `imm32` after edge N, with `out_valid` = 1.
- `in_valid` = 0 at an edge: `imm32` holds its previous value and `out_valid` goes 0.
- Throughput is one result per cycle. There is no backpressure and no stall input.
- Back-to-back valid inputs give back-to-back results with no bubbles.
- Changing `imm`/`Extop` while `in_valid` = 0 has no effect on the outputs.
- Reset asserted mid-stream discards any result not yet visible. Outputs go to their reset values at once.

## Structure
- Shared package `sign_extend_pkg` holds:
  - 2-bit `Extop` encodings: `EXT_ZERO24`, `EXT_SIGN24`, `EXT_BRANCH`, `EXT_SIGN12`.
  - Width constants: `IMM_W` = 24, `XLEN` = 32.
  - The decoder imports the same package.
- Sub-module `sign_extend_core` is a purely combinational mode mux that computes the 32-bit value.
- The top level `sign_extend` wraps `sign_extend_core` with the output register and the `out_valid` flop.

## Test plan
- `imm` = 24'h123456, `in_valid` = 1, `Extop` stepped 00 → 01 → 10 → 11 on consecutive cycles. Required `imm32`, one cycle later each: 32'h00123456, 32'h00123456, 32'h0048D158, 32'h00000456.
- `imm` = 24'hFFFFFF, `Extop` stepped 00 → 01 → 10 → 11. Required `imm32`: 32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFF.
- Sign boundaries:
  - `imm` = 24'h800000 with 01 → 32'hFF800000; with 10 → 32'hFE000000.
  - `imm` = 24'h7FF800 with 11 → 32'hFFFFF800; with 01 → 32'h007FF800.
- Hold behaviour: valid result 32'hFFFFFFFF, then `in_valid` = 0 with `imm` = 24'h000001. Required: `imm32` stays 32'hFFFFFFFF and `out_valid` = 0.
- Asynchronous reset: assert `rst_n` = 0 between clock edges while `out_valid` = 1. Required: `imm32` = 0 and `out_valid` = 0 before the next edge.
- Recovery: after `rst_n` deasserts, `imm` = 24'h000010 with 10. Required: 32'h00000040 one cycle later.
